game_round_sched: RTL and testbench
===================================

Name: game_round_sched

Overview:
Central sequencer for a whack-a-mole session. It starts a game, requests a fresh pattern from the pattern generator over a req/ack handshake, and times each round with an internal loadable countdown. It judges hit, wrong-press and expiry events, and tracks score, lives and difficulty level. It sits between the button-judging logic (upstream) and the pattern generator, 7-seg driver and score LEDs (downstream). It replaces ad-hoc round timing in the top level.

Parameters:
TW, 16, width of round and penalty counters
ROUND_BASE, 5000, round length in cycles at level 0
ROUND_STEP, 1000, cycles removed per level
ROUND_MIN, 2000, floor on round length
LEVEL_HITS, 5, consecutive-level hits needed to advance one level
MAX_LIVES, 3, lives at game start (1..7)
PENALTY_CYC, 500, blank cycles after a lost life

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a game from IDLE or OVER
pat_ack  in  1  pattern generator has latched a new pattern
hit  in  1  all lit segments pressed this cycle (already lockout-filtered)
wrong  in  1  an unlit segment pressed this cycle
pat_req  out  1  request for a new pattern
show  out  1  pattern visible / round live
num_lit  out  3  segments to light = level+1
round_left  out  TW  remaining round cycles
score  out  8  hits this game, saturating
lives  out  3  remaining lives
level  out  2  difficulty 0..3
game_over  out  1  high in OVER

Behaviour:
- One clock domain. Reset is asynchronous and active-high. On reset:
  - state=IDLE; all outputs 0 except num_lit=1.
  - Internal hit counter (hcnt) and penalty counter cleared.
- All outputs are registered.
- States: IDLE, FETCH, SHOW, PENALTY, OVER.
- IDLE:
  - start -> FETCH next cycle.
  - On that same edge: score=0, lives=MAX_LIVES, level=0, hcnt=0.
- FETCH:
  - pat_req=1 from the first FETCH cycle.
  - pat_ack is sampled every cycle. When seen: pat_req=0 next cycle, state->SHOW, round_left loaded with preset(level).
  - pat_ack outside FETCH is ignored.
  - No timeout on the handshake.
- preset(level) = max(ROUND_BASE - level*ROUND_STEP, ROUND_MIN), computed in TW+2 bits with no underflow.
- SHOW:
  - show=1; round_left decrements by 1 per cycle.
  - Per-cycle priority: hit > wrong > expiry (round_left==0).
  - hit:
    - score+1 (saturates at 255); hcnt+1.
    - If hcnt+1==LEVEL_HITS and level<3: level+1, hcnt=0.
    - If level==3: hcnt holds at LEVEL_HITS-1.
    - State -> FETCH.
  - wrong or expiry:
    - lives-1, hcnt=0.
    - If the new lives==0 -> OVER, else -> PENALTY with penalty counter = PENALTY_CYC-1.
  - hit and wrong in the same cycle counts as a hit.
  - hit in the same cycle round_left reaches 0 still counts as a hit.
- PENALTY:
  - show=0; counter decrements.
  - At 0 -> FETCH.
  - hit/wrong ignored.
- OVER:
  - game_over=1, show=0; score/level frozen for display.
  - start -> FETCH with the same clears as IDLE.
- start is ignored in FETCH, SHOW and PENALTY.
- num_lit is updated combinationally-registered from level every cycle.
- Reset mid-game: immediate return to IDLE values, and pat_req drops asynchronously.

Optional Feature:
GAME_PAUSE_EN
- Defined: adds port pause (in, 1).
  - While pause=1 in SHOW or PENALTY, all counters and state hold and hit/wrong are ignored; show stays at its current value.
  - pause in FETCH holds pat_req asserted but still accepts pat_ack.
  - pause has no effect in IDLE/OVER.
- Undefined: port absent; behaviour as above with pause permanently 0.

Decomposition:
- Shared package game_pkg holds:
  - enum sched_state_t {IDLE, FETCH, SHOW, PENALTY, OVER} (3-bit);
  - localparam MAX_LEVEL=2'd3;
  - function round_preset(level) used by the top level and the bench.
- One sub-module: round_countdown. It is a TW-bit loadable down-counter with load, en and zero outputs, holding at 0. It is instantiated twice: round timer and penalty timer.

Test Plan:
- Basic round: rst 1->0, start, ack 2 cycles after pat_req, hit 10 cycles into SHOW -> score=1, lives=3, FETCH entered next cycle, pat_req=1.
- Level progression: 5 consecutive hits -> level=1, num_lit=2, next round_left loads 4000. 15 more hits -> level=3 and preset=2000 (floor). A 20th+ hit keeps level=3.
- Expiry: no press for 5000 SHOW cycles -> round_left hits 0, lives=2, show=0 for exactly 500 cycles, then pat_req=1.
- Simultaneous: hit and wrong asserted in the same cycle with round_left=0 -> score+1, lives unchanged.
- Game over: 3 wrong presses -> game_over=1 after the third and score retained. start -> score=0, lives=3, pat_req=1 next cycle.
- Reset mid-SHOW with pat_req pending: assert rst -> all outputs to reset values without waiting for a clock edge.
- With GAME_PAUSE_EN: pause for 100 cycles mid-SHOW -> round_left unchanged across the pause, hit during pause ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the whack-a-mole round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SHOW    = 3'd2,
    PENALTY = 3'd3,
    OVER    = 3'd4
  } sched_state_t;

  localparam logic [1:0] MAX_LEVEL = 2'd3;

  // Round length for a level, floored at rmin; done wide so the subtraction never wraps.
  function automatic int round_preset(input logic [1:0] lvl, input int base,
                                      input int step, input int rmin);
    int dec;
    int len;
    dec = int'(lvl) * step;
    if (dec >= base) begin
      len = rmin;
    end else if (base - dec < rmin) begin
      len = rmin;
    end else begin
      len = base - dec;
    end
    return len;
  endfunction

endpackage

// File: rtl/round_countdown.sv
// Loadable down-counter that parks at zero; used for the round and penalty timers.
module round_countdown #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          zero
);

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/game_round_sched.sv
// Whack-a-mole session sequencer: pattern handshake, round timing, score/lives/level.
// Optional GAME_PAUSE_EN adds a pause input that freezes SHOW and PENALTY.
module game_round_sched
  import game_pkg::*;
#(
  parameter int TW          = 16,
  parameter int ROUND_BASE  = 5000,
  parameter int ROUND_STEP  = 1000,
  parameter int ROUND_MIN   = 2000,
  parameter int LEVEL_HITS  = 5,
  parameter int MAX_LIVES   = 3,
  parameter int PENALTY_CYC = 500
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pat_ack,
  input  logic          hit,
  input  logic          wrong,
`ifdef GAME_PAUSE_EN
  input  logic          pause,
`endif
  output logic          pat_req,
  output logic          show,
  output logic [2:0]    num_lit,
  output logic [TW-1:0] round_left,
  output logic [7:0]    score,
  output logic [2:0]    lives,
  output logic [1:0]    level,
  output logic          game_over
);

  sched_state_t  state_r;
  logic [7:0]    hcnt_r;
  logic          pause_s;
  logic          hit_ev_s;
  logic          miss_ev_s;
  logic          round_load_s;
  logic          round_en_s;
  logic          round_zero_s;
  logic          pen_load_s;
  logic          pen_en_s;
  logic          pen_zero_s;
  logic [TW-1:0] pen_cnt_s;
  logic [TW-1:0] preset_s;

`ifdef GAME_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign preset_s = TW'(round_preset(level, ROUND_BASE, ROUND_STEP, ROUND_MIN));

  // Event decode and timer controls; hit outranks wrong, which outranks expiry.
  always_comb begin
    hit_ev_s     = 1'b0;
    miss_ev_s    = 1'b0;
    round_load_s = 1'b0;
    round_en_s   = 1'b0;
    pen_load_s   = 1'b0;
    pen_en_s     = 1'b0;
    case (state_r)
      FETCH: begin
        round_load_s = pat_ack;
      end
      SHOW: begin
        round_en_s = !pause_s;
        hit_ev_s   = !pause_s && hit;
        miss_ev_s  = !pause_s && !hit && (wrong || round_zero_s);
        pen_load_s = miss_ev_s && (lives != 3'd1);
      end
      PENALTY: begin
        pen_en_s = !pause_s && (pen_cnt_s != '0);
      end
      default: begin
        round_load_s = 1'b0;
      end
    endcase
  end

  round_countdown #(.TW(TW)) u_round_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (round_load_s),
    .load_val (preset_s),
    .en       (round_en_s),
    .count    (round_left),
    .zero     (round_zero_s)
  );

  round_countdown #(.TW(TW)) u_penalty_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (pen_load_s),
    .load_val (TW'(PENALTY_CYC - 1)),
    .en       (pen_en_s),
    .count    (pen_cnt_s),
    .zero     (pen_zero_s)
  );

  // Session state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pat_req   <= 1'b0;
      show      <= 1'b0;
      num_lit   <= 3'd1;
      score     <= 8'd0;
      lives     <= 3'd0;
      level     <= 2'd0;
      game_over <= 1'b0;
      hcnt_r    <= 8'd0;
    end else begin
      num_lit <= {1'b0, level} + 3'd1;
      case (state_r)
        IDLE, OVER: begin
          if (start) begin
            state_r   <= FETCH;
            pat_req   <= 1'b1;
            show      <= 1'b0;
            game_over <= 1'b0;
            score     <= 8'd0;
            lives     <= 3'(MAX_LIVES);
            level     <= 2'd0;
            hcnt_r    <= 8'd0;
          end
        end
        FETCH: begin
          if (pat_ack) begin
            state_r <= SHOW;
            pat_req <= 1'b0;
            show    <= 1'b1;
          end
        end
        SHOW: begin
          if (hit_ev_s) begin
            state_r <= FETCH;
            pat_req <= 1'b1;
            show    <= 1'b0;
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
            if ((hcnt_r + 8'd1 == 8'(LEVEL_HITS)) && (level < MAX_LEVEL)) begin
              level  <= level + 2'd1;
              hcnt_r <= 8'd0;
            end else if (hcnt_r + 8'd1 >= 8'(LEVEL_HITS)) begin
              hcnt_r <= 8'(LEVEL_HITS - 1);
            end else begin
              hcnt_r <= hcnt_r + 8'd1;
            end
          end else if (miss_ev_s) begin
            show   <= 1'b0;
            lives  <= lives - 3'd1;
            hcnt_r <= 8'd0;
            if (lives == 3'd1) begin
              state_r   <= OVER;
              game_over <= 1'b1;
            end else begin
              state_r <= PENALTY;
            end
          end
        end
        PENALTY: begin
          if (!pause_s && pen_zero_s) begin
            state_r <= FETCH;
            pat_req <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_sched.sv
// Directed self-checking bench for game_round_sched (default parameters).
module tb_game_round_sched;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pat_ack = 1'b0;
  logic        hit = 1'b0;
  logic        wrong = 1'b0;
  logic        pause = 1'b0;
  logic        pat_req;
  logic        show;
  logic [2:0]  num_lit;
  logic [15:0] round_left;
  logic [7:0]  score;
  logic [2:0]  lives;
  logic [1:0]  level;
  logic        game_over;

  int checks = 0;
  int failures = 0;
  int n;
  int pre_tbl [4] = '{5000, 4000, 3000, 2000};

  game_round_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pat_ack    (pat_ack),
    .hit        (hit),
    .wrong      (wrong),
`ifdef GAME_PAUSE_EN
    .pause      (pause),
`endif
    .pat_req    (pat_req),
    .show       (show),
    .num_lit    (num_lit),
    .round_left (round_left),
    .score      (score),
    .lives      (lives),
    .level      (level),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (pat_req !== 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    chk("pat_req_wait", 32'(pat_req), 32'd1);
  endtask

  task automatic ack_round();
    wait_req();
    pat_ack = 1'b1;
    tick();
    pat_ack = 1'b0;
  endtask

  task automatic wait_zero(output int cnt);
    cnt = 0;
    while (round_left != 16'd0 && cnt < 6000) begin
      tick();
      cnt++;
    end
  endtask

  function automatic int lvl_of(input int hits);
    return (hits / 5 > 3) ? 3 : hits / 5;
  endfunction

  initial begin
    // reset values
    tick(); tick();
    chk("rst_pat_req", 32'(pat_req), 32'd0);
    chk("rst_show", 32'(show), 32'd0);
    chk("rst_num_lit", 32'(num_lit), 32'd1);
    chk("rst_round_left", 32'(round_left), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    tick();

    // basic round
    start = 1'b1; tick(); start = 1'b0;
    chk("start_pat_req", 32'(pat_req), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    tick(); tick();
    chk("fetch_hold_req", 32'(pat_req), 32'd1);
    pat_ack = 1'b1; tick(); pat_ack = 1'b0;
    chk("show_on", 32'(show), 32'd1);
    chk("show_req_low", 32'(pat_req), 32'd0);
    chk("preset_l0", 32'(round_left), 32'd5000);
    repeat (9) tick();
    chk("round_left_10", 32'(round_left), 32'd4991);
    hit = 1'b1; tick(); hit = 1'b0;
    chk("hit1_score", 32'(score), 32'd1);
    chk("hit1_lives", 32'(lives), 32'd3);
    chk("hit1_pat_req", 32'(pat_req), 32'd1);
    chk("hit1_show", 32'(show), 32'd0);

    // level progression over 19 more hits
    for (int i = 2; i <= 20; i++) begin
      ack_round();
      chk("lvl_preset", 32'(round_left), 32'(pre_tbl[lvl_of(i - 1)]));
      chk("lvl_num_lit", 32'(num_lit), 32'(lvl_of(i - 1) + 1));
      repeat (3) tick();
      hit = 1'b1; tick(); hit = 1'b0;
      chk("lvl_score", 32'(score), 32'(i));
      chk("lvl_level", 32'(level), 32'(lvl_of(i)));
    end

    // expiry at level 3 (2000-cycle floor) then 500-cycle penalty
    ack_round();
    chk("exp_preset", 32'(round_left), 32'd2000);
    wait_zero(n);
    chk("exp_cycles", 32'(n), 32'd2000);
    chk("exp_show_at0", 32'(show), 32'd1);
    tick();
    chk("exp_lives", 32'(lives), 32'd2);
    chk("exp_show_off", 32'(show), 32'd0);
    n = 0;
    while (pat_req !== 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    chk("penalty_len", 32'(n), 32'd500);

    // hit and wrong together with round_left at zero counts as a hit
    ack_round();
    wait_zero(n);
    hit = 1'b1; wrong = 1'b1; tick(); hit = 1'b0; wrong = 1'b0;
    chk("sim_score", 32'(score), 32'd21);
    chk("sim_lives", 32'(lives), 32'd2);
    chk("sim_pat_req", 32'(pat_req), 32'd1);

    // two wrong presses end the game; hit ignored during penalty
    ack_round();
    tick();
    wrong = 1'b1; tick(); wrong = 1'b0;
    chk("wr1_lives", 32'(lives), 32'd1);
    chk("wr1_show", 32'(show), 32'd0);
    tick();
    hit = 1'b1; tick(); hit = 1'b0;
    chk("pen_hit_ignored", 32'(score), 32'd21);
    ack_round();
    wrong = 1'b1; tick(); wrong = 1'b0;
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_score", 32'(score), 32'd21);
    chk("over_level", 32'(level), 32'd3);
    pat_ack = 1'b1; tick(); pat_ack = 1'b0;
    chk("over_ack_ignored", 32'(show), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_level", 32'(level), 32'd0);
    chk("restart_req", 32'(pat_req), 32'd1);
    chk("restart_over", 32'(game_over), 32'd0);

`ifdef GAME_PAUSE_EN
    // pause mid-SHOW freezes the timer and masks presses
    ack_round();
    repeat (5) tick();
    pause = 1'b1;
    repeat (50) tick();
    hit = 1'b1; tick(); hit = 1'b0;
    repeat (49) tick();
    chk("pause_hold", 32'(round_left), 32'd4995);
    chk("pause_hit_ignored", 32'(score), 32'd0);
    chk("pause_show", 32'(show), 32'd1);
    pause = 1'b0;
    tick();
    chk("pause_resume", 32'(round_left), 32'd4994);
`else
    ack_round();
`endif

    // one hit, then asynchronous reset while the next pat_req is pending
    repeat (3) tick();
    hit = 1'b1; tick(); hit = 1'b0;
    chk("pre_rst_score", 32'(score), 32'd1);
    chk("pre_rst_req", 32'(pat_req), 32'd1);
    rst = 1'b1;
    #2;
    chk("arst_pat_req", 32'(pat_req), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_lives", 32'(lives), 32'd0);
    chk("arst_round_left", 32'(round_left), 32'd0);
    chk("arst_num_lit", 32'(num_lit), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(pat_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
